// File: rtl/rf_write_arbiter_pkg.sv
// rtl/rf_write_arbiter_pkg.sv - shared types and defaults for the register file write arbiter
//
// Purpose : state and requester encodings plus default widths used by
//           rf_write_arbiter and rr_arb2.
// Ports   : none (package).
package rf_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;

  // Sweep/arbitrate controller states.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    ARB   = 1'b1
  } state_e;

  // Requester identities; also the encoding of the round-robin priority.
  typedef enum logic [0:0] {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/rf_write_arbiter_rr_arb2.sv
// rtl/rf_write_arbiter_rr_arb2.sv - two-input round-robin arbiter
//
// Purpose : grants one of two requesters per cycle; on a tie the requester
//           named by the internal priority register wins.
// Ports   : clk     - clock
//           rst     - asynchronous active-low reset
//           req     - request vector, bit 0 = A, bit 1 = B
//           advance - a grant was taken this cycle; update priority
//           gnt     - one-hot (or zero) grant vector, same bit order as req
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  req_id_e r_pri;

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = (r_pri == REQ_B) ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

  // Whoever was just granted drops to lowest priority, whether or not
  // there was contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pri <= REQ_A;
    end else if (advance) begin
      r_pri <= gnt[0] ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - shares the register file write port between two requesters
//
// Purpose : owns wa/wd/we of the register file. After reset or clr_start it
//           sweeps CLR_VAL into every entry, then arbitrates requesters A
//           (writeback) and B (debug/loader) round-robin, one write per cycle.
// Ports   : clk, rst (async active-low)
//           a_valid/a_addr/a_data/a_ready - requester A write channel
//           b_valid/b_addr/b_data/b_ready - requester B write channel
//           clr_start - one-cycle pulse starting a clear sweep (ignored while sweeping)
//           busy      - clear sweep in progress
//           rf_we/rf_wa/rf_wd - registered register file write port
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int              AW      = AW_DEF,
  parameter int              DW      = DW_DEF,
  parameter logic [DW-1:0]   CLR_VAL = '0,
  parameter bit              ZERO_RO = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  input  logic          clr_start,
  output logic          busy,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd
);

  state_e        r_state;
  logic [AW-1:0] r_clr_ptr;
  logic          r_we;
  logic [AW-1:0] r_wa;
  logic [DW-1:0] r_wd;

  logic [1:0]    w_req;
  logic [1:0]    w_gnt;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          w_drop;

  // Requests are masked while sweeping and in the cycle clr_start arrives,
  // so a clear always wins over pending writes.
  assign w_req = (r_state == ARB && !clr_start) ? {b_valid, a_valid} : 2'b00;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .req     (w_req),
    .advance (|w_gnt),
    .gnt     (w_gnt)
  );

  assign a_ready = w_gnt[0];
  assign b_ready = w_gnt[1];
  assign busy    = (r_state == CLEAR);

  assign w_addr = w_gnt[1] ? b_addr : a_addr;
  assign w_data = w_gnt[1] ? b_data : a_data;
  // Address 0 is hard-wired in the register file view: the write is
  // acknowledged to the requester but never reaches the port.
  assign w_drop = ZERO_RO && (w_addr == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
      r_we      <= 1'b0;
      r_wa      <= '0;
      r_wd      <= '0;
    end else if (r_state == CLEAR) begin
      // The sweep writes every entry, address 0 included, whatever ZERO_RO.
      r_we      <= 1'b1;
      r_wa      <= r_clr_ptr;
      r_wd      <= CLR_VAL;
      r_clr_ptr <= r_clr_ptr + {{(AW-1){1'b0}}, 1'b1};
      if (r_clr_ptr == '1) begin
        r_state <= ARB;
      end
    end else if (clr_start) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
      r_we      <= 1'b0;
    end else if ((|w_gnt) && !w_drop) begin
      r_we <= 1'b1;
      r_wa <= w_addr;
      r_wd <= w_data;
    end else begin
      r_we <= 1'b0;
    end
  end

  assign rf_we = r_we;
  assign rf_wa = r_wa;
  assign rf_wd = r_wd;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        clr_start;
  logic        busy;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  int checks;
  int errors;

  rf_write_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .clr_start (clr_start),
    .busy      (busy),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expects a full 32-entry sweep starting at the current negedge, with the
  // state already in CLEAR.
  task automatic sweep(input string tag, input bit pulse_mid);
    for (int i = 0; i < 32; i++) begin
      check({tag, " busy"}, 64'(busy), 64'd1);
      check({tag, " a_ready"}, 64'(a_ready), 64'd0);
      clr_start = pulse_mid && (i == 5);
      tick();
      clr_start = 1'b0;
      check({tag, " we"}, 64'(rf_we), 64'd1);
      check({tag, " wa"}, 64'(rf_wa), 64'(i));
      check({tag, " wd"}, 64'(rf_wd), 64'd0);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    a_valid   = 1'b0;
    a_addr    = '0;
    a_data    = '0;
    b_valid   = 1'b0;
    b_addr    = '0;
    b_data    = '0;
    clr_start = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst busy", 64'(busy), 64'd1);
    check("rst we", 64'(rf_we), 64'd0);
    check("rst wa", 64'(rf_wa), 64'd0);
    check("rst wd", 64'(rf_wd), 64'd0);
    check("rst a_ready", 64'(a_ready), 64'd0);
    check("rst b_ready", 64'(b_ready), 64'd0);

    // Post-reset sweep
    rst = 1'b1;
    sweep("sweep1", 1'b0);
    check("sweep1 end busy", 64'(busy), 64'd0);
    tick();
    check("idle we", 64'(rf_we), 64'd0);
    check("idle wa hold", 64'(rf_wa), 64'd31);

    // Single A write
    a_valid = 1'b1; a_addr = 5'h03; a_data = 32'h87654321;
    #1;
    check("A a_ready", 64'(a_ready), 64'd1);
    check("A b_ready", 64'(b_ready), 64'd0);
    tick();
    a_valid = 1'b0;
    check("A we", 64'(rf_we), 64'd1);
    check("A wa", 64'(rf_wa), 64'h03);
    check("A wd", 64'(rf_wd), 64'h87654321);

    // Single B write; priority then returns to A
    b_valid = 1'b1; b_addr = 5'h10; b_data = 32'h12345678;
    #1;
    check("B b_ready", 64'(b_ready), 64'd1);
    check("B a_ready", 64'(a_ready), 64'd0);
    tick();
    b_valid = 1'b0;
    check("B we", 64'(rf_we), 64'd1);
    check("B wa", 64'(rf_wa), 64'h10);
    check("B wd", 64'(rf_wd), 64'h12345678);

    // Contention for 4 cycles: A,B,A,B back to back
    a_valid = 1'b1;
    b_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr a_ready", 64'(a_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
      check("rr b_ready", 64'(b_ready), (i % 2 == 0) ? 64'd0 : 64'd1);
      tick();
      check("rr we", 64'(rf_we), 64'd1);
      check("rr wa", 64'(rf_wa), (i % 2 == 0) ? 64'h03 : 64'h10);
      check("rr wd", 64'(rf_wd), (i % 2 == 0) ? 64'h87654321 : 64'h12345678);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;

    // Address 0 is read-only: acknowledged but not written
    a_valid = 1'b1; a_addr = 5'h00; a_data = 32'hFFFF_FFFF;
    #1;
    check("z0 a_ready", 64'(a_ready), 64'd1);
    tick();
    check("z0 we", 64'(rf_we), 64'd0);
    a_addr = 5'h01;
    #1;
    check("z1 a_ready", 64'(a_ready), 64'd1);
    tick();
    a_valid = 1'b0;
    check("z1 we", 64'(rf_we), 64'd1);
    check("z1 wa", 64'(rf_wa), 64'h01);
    check("z1 wd", 64'(rf_wd), 64'hFFFF_FFFF);

    // clr_start overrides a pending A request; restart pulse mid-sweep ignored
    a_valid = 1'b1; a_addr = 5'h02; a_data = 32'h0BAD_F00D;
    clr_start = 1'b1;
    #1;
    check("clr a_ready", 64'(a_ready), 64'd0);
    check("clr busy pre", 64'(busy), 64'd0);
    tick();
    clr_start = 1'b0;
    check("clr we", 64'(rf_we), 64'd0);
    sweep("sweep2", 1'b1);
    check("sweep2 end busy", 64'(busy), 64'd0);
    check("sweep2 first arb a_ready", 64'(a_ready), 64'd1);
    tick();
    a_valid = 1'b0;
    check("post clr we", 64'(rf_we), 64'd1);
    check("post clr wa", 64'(rf_wa), 64'h02);
    check("post clr wd", 64'(rf_wd), 64'h0BAD_F00D);

    // Asynchronous reset part-way through a sweep
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    check("mid wa", 64'(rf_wa), 64'd10);
    check("mid busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check("async we", 64'(rf_we), 64'd0);
    check("async wa", 64'(rf_wa), 64'd0);
    check("async busy", 64'(busy), 64'd1);
    tick();
    tick();
    rst = 1'b1;
    sweep("sweep3", 1'b0);
    check("sweep3 end busy", 64'(busy), 64'd0);
    tick();
    check("sweep3 idle we", 64'(rf_we), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
